// File: rtl/bcd_pkg.sv
// Shared types and constants for the streaming BCD modulus checker.
//   bcd_digit_t : one BCD digit (4 bits, legal values 0..9)
//   BCD_MAX     : largest legal BCD digit
//   state_t     : frame FSM states
//   ACC_W       : width of r*10+d intermediate (r < 99, d <= 15 -> < 2048)
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam int         ACC_W   = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_mod_step.sv
// One Horner step of a decimal remainder: r_out = (r_in*10 + digit) mod DIVISOR.
// Purely combinational.
//   r_in      : running remainder (already reduced, < DIVISOR)
//   digit     : incoming digit, MSD first
//   r_out     : updated remainder (meaningless when digit_bad=1)
//   digit_bad : digit is not a legal BCD value
module bcd_mod_step
  import bcd_pkg::*;
#(
  parameter int DIVISOR = 11,
  parameter int RW      = $clog2(DIVISOR)
) (
  input  logic [RW-1:0] r_in,
  input  bcd_digit_t    digit,
  output logic [RW-1:0] r_out,
  output logic          digit_bad
);
  logic [ACC_W-1:0] acc;

  assign acc       = ACC_W'(r_in) * ACC_W'(10) + ACC_W'(digit);
  assign r_out     = RW'(acc % ACC_W'(DIVISOR));
  assign digit_bad = (digit > BCD_MAX);
endmodule

// File: rtl/bcd_mod_stream.sv
// Streaming BCD divisibility checker. Takes one digit per accept (MSD first),
// closes a frame on in_last or when MAX_DIGITS digits have arrived, and
// presents a registered result held until res_ready.
//   clk, rst_n      : clock, synchronous active-low reset
//   in_valid/ready  : digit handshake; in_digit, in_last qualify it
//   res_valid/ready : result handshake; res_* fields stable while res_valid
//   res_divisible   : remainder==0 and no error
//   res_remainder   : value mod DIVISOR (non-BCD digits skipped)
//   res_digits      : digits accepted in the frame
//   res_error       : non-BCD digit seen, or frame forced closed at MAX_DIGITS
//   busy            : frame in progress (ACCUM or DONE)
module bcd_mod_stream
  import bcd_pkg::*;
#(
  parameter  int DIVISOR    = 11,
  parameter  int MAX_DIGITS = 8,
  localparam int RW         = $clog2(DIVISOR),
  localparam int CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  bcd_digit_t    in_digit,
  input  logic          in_last,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_divisible,
  output logic [RW-1:0] res_remainder,
  output logic [CW-1:0] res_digits,
  output logic          res_error,
  output logic          busy
);
  state_t        state_q, state_d;
  logic [RW-1:0] rem_q, r_base, r_step, rem_new;
  logic [CW-1:0] cnt_q, cnt_new;
  logic          err_q, err_new;
  logic          bad, accept, close;

  logic          res_div_q, res_err_q;
  logic [RW-1:0] res_rem_q;
  logic [CW-1:0] res_cnt_q;

  assign in_ready = (state_q != DONE);
  assign accept   = in_valid && in_ready;

  // A digit accepted in IDLE starts a fresh frame, so the running values
  // are taken as zero there instead of clearing them on every handshake.
  assign r_base  = (state_q == IDLE) ? '0 : rem_q;
  assign cnt_new = ((state_q == IDLE) ? '0 : cnt_q) + CW'(1);

  bcd_mod_step #(.DIVISOR(DIVISOR), .RW(RW)) u_step (
    .r_in      (r_base),
    .digit     (in_digit),
    .r_out     (r_step),
    .digit_bad (bad)
  );

  // A bad digit is counted but does not disturb the remainder.
  assign rem_new = bad ? r_base : r_step;
  assign close   = accept && (in_last || cnt_new == CW'(MAX_DIGITS));
  assign err_new = ((state_q == ACCUM) && err_q) || bad || (close && !in_last);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = close ? DONE : ACCUM;
      ACCUM:   if (close)  state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      res_div_q <= 1'b0;
      res_err_q <= 1'b0;
      res_rem_q <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rem_q <= rem_new;
        cnt_q <= cnt_new;
        err_q <= err_new;
      end
      if (close) begin
        res_rem_q <= rem_new;
        res_cnt_q <= cnt_new;
        res_err_q <= err_new;
        res_div_q <= (rem_new == '0) && !err_new;
      end
    end
  end

  assign res_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign res_divisible = res_div_q;
  assign res_remainder = res_rem_q;
  assign res_digits    = res_cnt_q;
  assign res_error     = res_err_q;
endmodule

// File: tb/tb_bcd_mod_stream.sv
// Directed bench for bcd_mod_stream. Two instances share all inputs:
// DIVISOR=11 (main) and DIVISOR=7; both MAX_DIGITS=8 so they stay in lockstep.
module tb_bcd_mod_stream;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_last, res_ready;
  logic [3:0] in_digit;

  logic       in_ready, res_valid, res_divisible, res_error, busy;
  logic [3:0] res_remainder, res_digits;
  logic       in_ready7, res_valid7, res_divisible7, res_error7, busy7;
  logic [2:0] res_remainder7;
  logic [3:0] res_digits7;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_mod_stream #(.DIVISOR(11), .MAX_DIGITS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_digit(in_digit), .in_last(in_last), .res_valid(res_valid),
    .res_ready(res_ready), .res_divisible(res_divisible),
    .res_remainder(res_remainder), .res_digits(res_digits),
    .res_error(res_error), .busy(busy)
  );

  bcd_mod_stream #(.DIVISOR(7), .MAX_DIGITS(8)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready7),
    .in_digit(in_digit), .in_last(in_last), .res_valid(res_valid7),
    .res_ready(res_ready), .res_divisible(res_divisible7),
    .res_remainder(res_remainder7), .res_digits(res_digits7),
    .res_error(res_error7), .busy(busy7)
  );

  typedef struct {
    logic [31:0] hex;   // digits as hex nibbles, MSD first
    int          n;
    int          rem;
    int          div;
    int          err;
    int          rem7;
    int          div7;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".res_valid"}, res_valid, 0);
    chk({tag, ".divisible"}, res_divisible, 0);
    chk({tag, ".remainder"}, res_remainder, 0);
    chk({tag, ".digits"},    res_digits, 0);
    chk({tag, ".error"},     res_error, 0);
    chk({tag, ".busy"},      busy, 0);
    chk({tag, ".in_ready"},  in_ready, 1);
    chk({tag, ".res_valid7"}, res_valid7, 0);
    chk({tag, ".remainder7"}, res_remainder7, 0);
  endtask

  task automatic check_res(input string tag, input int rem, input int div, input int dig,
                           input int err, input int rem7, input int div7);
    chk({tag, ".res_valid"}, res_valid, 1);
    chk({tag, ".in_ready"},  in_ready, 0);
    chk({tag, ".busy"},      busy, 1);
    chk({tag, ".remainder"}, res_remainder, rem);
    chk({tag, ".divisible"}, res_divisible, div);
    chk({tag, ".digits"},    res_digits, dig);
    chk({tag, ".error"},     res_error, err);
    chk({tag, ".remainder7"}, res_remainder7, rem7);
    chk({tag, ".divisible7"}, res_divisible7, div7);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".res_valid"}, res_valid, 0);
    chk({tag, ".busy"},      busy, 0);
    chk({tag, ".in_ready"},  in_ready, 1);
  endtask

  // Drive a digit at the falling edge, wait (bounded) for in_ready, then let
  // the rising edge take it.
  task automatic send_digit(input logic [3:0] d, input logic last);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_digit = d;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait.in_ready", in_ready, 1);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [31:0] hex, input int n, input logic last_at_end);
    for (int i = 0; i < n; i++)
      send_digit(hex[4*(n-1-i) +: 4], last_at_end && (i == n - 1));
  endtask

  initial begin
    //            hex           n  rem div err rem7 div7
    vt[0] = '{32'h9999,     4, 0,  1,  0,  3,   0};
    vt[1] = '{32'h1234,     4, 2,  0,  0,  2,   0};
    vt[2] = '{32'h1001,     4, 0,  1,  0,  0,   1};
    vt[3] = '{32'h01A1,     3, 0,  0,  1,  4,   0};
    vt[4] = '{32'h0056,     2, 1,  0,  0,  0,   1};
    vt[5] = '{32'h0000,     1, 0,  1,  0,  0,   1};
    vt[6] = '{32'h98765432, 8, 7,  0,  0,  3,   0};

    rst_n = 1'b0; in_valid = 1'b0; in_digit = 4'd0; in_last = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Back-to-back frames, result consumed immediately
    for (int v = 0; v < 7; v++) begin
      send_frame(vt[v].hex, vt[v].n, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check_res($sformatf("vec%0d", v), vt[v].rem, vt[v].div, vt[v].n,
                vt[v].err, vt[v].rem7, vt[v].div7);
      @(posedge clk);
    end
    @(negedge clk);
    check_idle("after_table");

    // Forced close at MAX_DIGITS with a held result and a pending 9th digit
    res_ready = 1'b0;
    send_frame(32'h11111111, 8, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_digit = 4'd1; in_last = 1'b1;
    check_res("overflow", 0, 0, 8, 1, 4, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_res($sformatf("hold%0d", c), 0, 0, 8, 1, 4, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("post_handshake");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_res("ninth_digit", 1, 0, 1, 0, 1, 0);
    @(posedge clk);

    // Reset in the middle of a frame
    send_digit(4'd3, 1'b0);
    send_digit(4'd4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("midreset");
    rst_n = 1'b1;
    send_digit(4'd7, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check_res("after_reset", 7, 0, 1, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
